vc_input_buffer: RTL and testbench
==================================

Name: vc_input_buffer

Overview:
- Downstream end of a router-to-router link: accepts flits from the upstream router's output port and stores them in per-VC FIFOs.
- Returns per-VC on/off credit and per-VC allocatable status to the upstream side.
- Presents the head flit of each VC to the local routing/allocation stage, which pops it on demand.

Parameters:
- BUFFER_SIZE, 8, flit slots per VC; power of two, at least 4.
- OFF_THRESHOLD, 6, occupancy at or above which a VC signals off.
- ON_THRESHOLD, 2, occupancy at or below which a VC signals on again. Legal only if ON_THRESHOLD < OFF_THRESHOLD <= BUFFER_SIZE.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- data_i  input  $bits(flit_t)  incoming flit from upstream.
- is_valid_i  input  1  data_i valid this cycle.
- is_on_off_o  output  VC_NUM  per-VC credit; 1 means on (upstream may send).
- is_allocatable_o  output  VC_NUM  per-VC; 1 means the VC is free for a new packet.
- read_i  input  VC_NUM  per-VC pop request from the local stage.
- flit_o  output  VC_NUM x $bits(flit_t)  head flit of each VC FIFO (first-word fall-through).
- is_empty_o  output  VC_NUM  per-VC FIFO empty.

Behaviour:
- Reset values: all pointers and counts 0; is_empty_o all 1; is_on_off_o all 1; is_allocatable_o all 1; every VC FSM in IDLE; flit_o contents don't-care.
- Write: on a rising edge with is_valid_i=1, data_i is written to the FIFO selected by data_i.vc_id. The flit appears on flit_o[v] and is_empty_o[v] falls in the next cycle (1-cycle latency).
- Write to a full VC: flit dropped; pointers and count unchanged; no other state changes.
- Read: read_i[v]=1 with is_empty_o[v]=0 pops one flit at the edge. A read of an empty VC is ignored. read_i may have multiple bits set.
- Simultaneous read and write, same VC:
  - Non-empty: both happen; count unchanged.
  - Empty: only the write occurs.
  - Full: pop and push both occur.
- Pointers wrap modulo BUFFER_SIZE. Count width is $clog2(BUFFER_SIZE)+1.
- on/off (registered, computed from next-state count):
  - Clears to 0 when next count >= OFF_THRESHOLD.
  - Sets to 1 when next count <= ON_THRESHOLD.
  - Otherwise holds (hysteresis).
- Allocatable FSM per VC:
  - States: IDLE (allocatable=1), BUSY, TAIL_IN (both allocatable=0).
  - IDLE -> BUSY on a HEAD write.
  - IDLE -> TAIL_IN on a HEADTAIL write.
  - BUSY -> TAIL_IN on a TAIL write.
  - TAIL_IN -> IDLE on the edge where the last stored flit is popped (next count = 0).
  - A HEAD or HEADTAIL write in a non-IDLE state is a protocol violation: the flit is stored, the state is unchanged.
  - is_allocatable_o is registered (it is the registered FSM state decode).
  - A BODY or TAIL write in IDLE is stored; the state is unchanged.
- Reset asserted mid-packet immediately empties all VCs and returns all outputs to their reset values.

Optional Feature:
- Macro NOC_INBUF_OVERFLOW_DET_EN.
- Defined:
  - Adds output overflow_o (1 bit), a sticky flag set the cycle after any write to a full VC; cleared only by rst.
  - Adds an immediate assertion on the same condition.
- Undefined: no port and no logic; overflowing writes are silently dropped as specified above.

Decomposition:
- noc_pkg holds:
  - flit_t, with fields flit_label, vc_id and payload.
  - flit_label_t enum: HEAD, BODY, TAIL, HEADTAIL.
  - VC_NUM.
  - vc_alloc_state_t enum: IDLE, BUSY, TAIL_IN.
- Sub-module vc_fifo: single-VC circular FIFO with parameter BUFFER_SIZE and ports for write, read, head, empty, full and count.
  - Instantiated VC_NUM times from a generate loop.
  - Thresholds and the FSM stay in vc_input_buffer.

Test Plan:
- Reset, then idle 3 cycles -> is_on_off_o all 1, is_allocatable_o all 1, is_empty_o all 1.
- VC0 HEAD, BODY, TAIL on consecutive cycles, then read_i[0] for 3 cycles starting 2 cycles later:
  - is_allocatable_o[0]=0 the cycle after HEAD.
  - flit_o[0] shows HEAD, BODY, TAIL in order.
  - is_allocatable_o[0]=1 the cycle after the TAIL pop.
- 6 flits to VC1 with no reads -> is_on_off_o[1]=0 the cycle after the 6th write. Pop 3 -> still 0 at count 3. Pop the 4th -> 1 at count 2.
- Fill VC0 to 8, then write a 9th with read_i[0]=0 -> count stays 8 and the 9th flit is absent. With the macro defined, overflow_o=1 next cycle.
- Empty VC2, HEADTAIL write with read_i[2]=1 the same cycle -> read ignored; flit present next cycle. Read it -> is_allocatable_o[2]=1 the next cycle.
- VC0 and VC1 each hold 2 flits; pulse rst mid-stream -> all outputs return to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared types and constants for the router input-buffer slice.
//   flit_label_t     : HEAD / BODY / TAIL / HEADTAIL packet framing label
//   flit_t           : {flit_label, vc_id, payload}
//   vc_alloc_state_t : per-VC allocation state (IDLE / BUSY / TAIL_IN)
//   VC_NUM           : number of virtual channels per link
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int VC_NUM    = 4;
    localparam int VC_W      = $clog2(VC_NUM);
    localparam int PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t           flit_label;
        logic [VC_W-1:0]       vc_id;
        logic [PAYLOAD_W-1:0]  payload;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        TAIL_IN = 2'd2
    } vc_alloc_state_t;

    // True for labels that open a new packet.
    function automatic logic is_head_label(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo
// Single-VC circular FIFO with first-word fall-through head output.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : push wr_data (ignored when full unless a pop happens too)
//   wr_data   : flit to store
//   rd_en     : pop the head (ignored when empty)
//   head      : flit at the read pointer (valid when !empty)
//   empty     : no flits stored
//   full      : BUFFER_SIZE flits stored
//   count     : number of flits stored
// -----------------------------------------------------------------------------
module vc_fifo
    import noc_pkg::*;
#(
    parameter int BUFFER_SIZE = 8,
    localparam int PTR_W = $clog2(BUFFER_SIZE),
    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  flit_t            wr_data,
    input  logic             rd_en,
    output flit_t            head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    flit_t             mem_r [BUFFER_SIZE];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              rd_accept_s;
    logic              wr_accept_s;
    logic              empty_s;
    logic              full_s;

    // Accept qualification: a full FIFO still takes a write when it is popped in the same cycle.
    always_comb begin
        empty_s     = (count_r == {CNT_W{1'b0}});
        full_s      = (count_r == CNT_W'(BUFFER_SIZE));
        rd_accept_s = rd_en & ~empty_s;
        wr_accept_s = wr_en & (~full_s | rd_accept_s);
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally since BUFFER_SIZE is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = empty_s;
    assign full  = full_s;
    assign count = count_r;

endmodule

// File: rtl/vc_input_buffer.sv
// -----------------------------------------------------------------------------
// vc_input_buffer
// Downstream end of a router link: per-VC FIFOs, on/off credit with hysteresis
// and per-VC packet allocation tracking.
//   clk, rst          : clock, asynchronous active-high reset
//   data_i            : incoming flit; data_i.vc_id selects the VC FIFO
//   is_valid_i        : data_i valid this cycle
//   is_on_off_o[v]    : 1 = upstream may send on VC v
//   is_allocatable_o  : 1 = VC v is free for a new packet
//   read_i[v]         : pop request for VC v from the local stage
//   flit_o[v]         : head flit of VC v (first-word fall-through)
//   is_empty_o[v]     : VC v holds no flits
// Optional build macro NOC_INBUF_OVERFLOW_DET_EN adds overflow_o, a sticky flag
// set the cycle after any write to a full VC is dropped (cleared by rst only).
// -----------------------------------------------------------------------------
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter int BUFFER_SIZE   = 8,
    parameter int OFF_THRESHOLD = 6,
    parameter int ON_THRESHOLD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  flit_t               data_i,
    input  logic                is_valid_i,
    output logic [VC_NUM-1:0]   is_on_off_o,
    output logic [VC_NUM-1:0]   is_allocatable_o,
    input  logic [VC_NUM-1:0]   read_i,
    output flit_t [VC_NUM-1:0]  flit_o,
    output logic [VC_NUM-1:0]   is_empty_o
`ifdef NOC_INBUF_OVERFLOW_DET_EN
    ,
    output logic                overflow_o
`endif
);

    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

    logic [VC_NUM-1:0]  wr_sel_s;
    logic [VC_NUM-1:0]  wr_acc_s;
    logic [VC_NUM-1:0]  rd_acc_s;
    logic [VC_NUM-1:0]  empty_s;
    logic [VC_NUM-1:0]  full_s;
    logic [CNT_W-1:0]   count_s      [VC_NUM];
    logic [CNT_W-1:0]   count_next_s [VC_NUM];
    logic [VC_NUM-1:0]  on_off_r;
    logic [VC_NUM-1:0]  alloc_r;
    vc_alloc_state_t    state_r      [VC_NUM];

    // Per-VC write select plus the same accept rule the FIFO applies, for count prediction.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            wr_sel_s[v] = is_valid_i & (data_i.vc_id == VC_W'(v));
            rd_acc_s[v] = read_i[v] & ~empty_s[v];
            wr_acc_s[v] = wr_sel_s[v] & (~full_s[v] | rd_acc_s[v]);
            case ({wr_acc_s[v], rd_acc_s[v]})
                2'b10:   count_next_s[v] = count_s[v] + CNT_W'(1);
                2'b01:   count_next_s[v] = count_s[v] - CNT_W'(1);
                default: count_next_s[v] = count_s[v];
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < VC_NUM; g++) begin : g_vc
            vc_fifo #(
                .BUFFER_SIZE (BUFFER_SIZE)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (wr_sel_s[g]),
                .wr_data (data_i),
                .rd_en   (read_i[g]),
                .head    (flit_o[g]),
                .empty   (empty_s[g]),
                .full    (full_s[g]),
                .count   (count_s[g])
            );
        end
    endgenerate

    // On/off credit with hysteresis, evaluated on the count the FIFO will hold after this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_off_r <= {VC_NUM{1'b1}};
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (count_next_s[v] >= CNT_W'(OFF_THRESHOLD)) begin
                    on_off_r[v] <= 1'b0;
                end else if (count_next_s[v] <= CNT_W'(ON_THRESHOLD)) begin
                    on_off_r[v] <= 1'b1;
                end else begin
                    on_off_r[v] <= on_off_r[v];
                end
            end
        end
    end

    // Allocation FSM per VC; stray HEAD/HEADTAIL in a busy VC and BODY/TAIL in IDLE leave state alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_r <= {VC_NUM{1'b1}};
            for (int v = 0; v < VC_NUM; v++) begin
                state_r[v] <= IDLE;
            end
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                case (state_r[v])
                    IDLE: begin
                        if (wr_acc_s[v] && is_head_label(data_i.flit_label)) begin
                            state_r[v] <= (data_i.flit_label == HEADTAIL) ? TAIL_IN : BUSY;
                            alloc_r[v] <= 1'b0;
                        end else begin
                            state_r[v] <= IDLE;
                            alloc_r[v] <= 1'b1;
                        end
                    end
                    BUSY: begin
                        if (wr_acc_s[v] && (data_i.flit_label == TAIL)) begin
                            state_r[v] <= TAIL_IN;
                        end else begin
                            state_r[v] <= BUSY;
                        end
                        alloc_r[v] <= 1'b0;
                    end
                    TAIL_IN: begin
                        if (rd_acc_s[v] && (count_next_s[v] == {CNT_W{1'b0}})) begin
                            state_r[v] <= IDLE;
                            alloc_r[v] <= 1'b1;
                        end else begin
                            state_r[v] <= TAIL_IN;
                            alloc_r[v] <= 1'b0;
                        end
                    end
                    default: begin
                        state_r[v] <= IDLE;
                        alloc_r[v] <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef NOC_INBUF_OVERFLOW_DET_EN
    logic [VC_NUM-1:0] drop_s;
    logic              overflow_r;

    // A write is dropped only when its VC is full and is not popped in the same cycle.
    always_comb begin
        drop_s = wr_sel_s & full_s & ~rd_acc_s;
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (|drop_s);
        end
    end

    // Flag a dropped write as it happens.
    always @(posedge clk) begin
        if (!rst) begin
            assert (drop_s == {VC_NUM{1'b0}})
                else $warning("vc_input_buffer: write to full VC dropped (vc mask %b)", drop_s);
        end
    end

    assign overflow_o = overflow_r;
`endif

    assign is_on_off_o      = on_off_r;
    assign is_allocatable_o = alloc_r;
    assign is_empty_o       = empty_s;

endmodule

// File: tb/tb_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_vc_input_buffer
// Directed bench for vc_input_buffer. A per-VC queue holds the flits the bench
// expects each FIFO to contain; writes push into it and pops compare flit_o
// against its front before removing it.
// -----------------------------------------------------------------------------
module tb_vc_input_buffer;
    import noc_pkg::*;

    localparam int BS = 8;

    logic               clk;
    logic               rst;
    flit_t              data_i;
    logic               is_valid_i;
    logic [VC_NUM-1:0]  is_on_off_o;
    logic [VC_NUM-1:0]  is_allocatable_o;
    logic [VC_NUM-1:0]  read_i;
    flit_t [VC_NUM-1:0] flit_o;
    logic [VC_NUM-1:0]  is_empty_o;
`ifdef NOC_INBUF_OVERFLOW_DET_EN
    logic               overflow_o;
`endif

    int total = 0;
    int bad   = 0;

    flit_t sb_q [VC_NUM][$];

    vc_input_buffer #(
        .BUFFER_SIZE   (BS),
        .OFF_THRESHOLD (6),
        .ON_THRESHOLD  (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .is_valid_i       (is_valid_i),
        .is_on_off_o      (is_on_off_o),
        .is_allocatable_o (is_allocatable_o),
        .read_i           (read_i),
        .flit_o           (flit_o),
        .is_empty_o       (is_empty_o)
`ifdef NOC_INBUF_OVERFLOW_DET_EN
        ,
        .overflow_o       (overflow_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_t mk(input flit_label_t l, input int vc, input logic [15:0] p);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_W'(vc);
        f.payload    = p;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; the model pops first, then pushes if room remains.
    task automatic drive(input logic v, input int vc, input flit_label_t l,
                         input logic [15:0] p, input logic [VC_NUM-1:0] rd);
        flit_t f;
        f          = mk(l, vc, p);
        data_i     = f;
        is_valid_i = v;
        read_i     = rd;
        for (int i = 0; i < VC_NUM; i++) begin
            if (rd[i] && (sb_q[i].size() > 0)) begin
                chk("pop_head", 32'(flit_o[i]), 32'(sb_q[i][0]));
                void'(sb_q[i].pop_front());
            end
        end
        if (v && (sb_q[vc].size() < BS)) begin
            sb_q[vc].push_back(f);
        end
        step();
        is_valid_i = 1'b0;
        read_i     = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            chk("empty", 32'(is_empty_o[i]), 32'(sb_q[i].size() == 0));
            if (sb_q[i].size() > 0) begin
                chk("head", 32'(flit_o[i]), 32'(sb_q[i][0]));
            end
        end
    endtask

    task automatic wr(input int vc, input flit_label_t l, input logic [15:0] p);
        drive(1'b1, vc, l, p, '0);
    endtask

    task automatic pop(input int vc);
        logic [VC_NUM-1:0] m;
        m     = '0;
        m[vc] = 1'b1;
        drive(1'b0, 0, BODY, 16'h0000, m);
    endtask

    initial begin
        rst        = 1'b1;
        data_i     = '0;
        is_valid_i = 1'b0;
        read_i     = '0;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_on_off", 32'(is_on_off_o), 32'(4'hF));
        chk("rst_alloc",  32'(is_allocatable_o), 32'(4'hF));
        chk("rst_empty",  32'(is_empty_o), 32'(4'hF));
`ifdef NOC_INBUF_OVERFLOW_DET_EN
        chk("rst_ovf", 32'(overflow_o), 32'(1'b0));
`endif

        // VC0 packet HEAD/BODY/TAIL, then popped two cycles later
        wr(0, HEAD, 16'h1001);
        chk("alloc0_after_head", 32'(is_allocatable_o[0]), 32'(1'b0));
        wr(0, BODY, 16'h1002);
        wr(0, TAIL, 16'h1003);
        repeat (2) step();
        chk("alloc0_busy", 32'(is_allocatable_o[0]), 32'(1'b0));
        pop(0);
        pop(0);
        chk("alloc0_before_last", 32'(is_allocatable_o[0]), 32'(1'b0));
        pop(0);
        chk("alloc0_after_tail_pop", 32'(is_allocatable_o[0]), 32'(1'b1));

        // VC1 on/off hysteresis
        for (int i = 0; i < 5; i++) wr(1, BODY, 16'h2000 + 16'(i));
        chk("onoff1_cnt5", 32'(is_on_off_o[1]), 32'(1'b1));
        wr(1, BODY, 16'h2005);
        chk("onoff1_cnt6", 32'(is_on_off_o[1]), 32'(1'b0));
        chk("alloc1_body_idle", 32'(is_allocatable_o[1]), 32'(1'b1));
        for (int i = 0; i < 3; i++) pop(1);
        chk("onoff1_cnt3", 32'(is_on_off_o[1]), 32'(1'b0));
        pop(1);
        chk("onoff1_cnt2", 32'(is_on_off_o[1]), 32'(1'b1));
        pop(1);
        pop(1);

        // VC0 full, dropped 9th write, then push+pop while full
        for (int i = 0; i < BS; i++) wr(0, BODY, 16'h3000 + 16'(i));
        chk("onoff0_full", 32'(is_on_off_o[0]), 32'(1'b0));
        wr(0, BODY, 16'hDEAD);
`ifdef NOC_INBUF_OVERFLOW_DET_EN
        chk("ovf_set", 32'(overflow_o), 32'(1'b1));
`endif
        drive(1'b1, 0, BODY, 16'h3AAA, 4'b0001);
        chk("onoff0_full_rw", 32'(is_on_off_o[0]), 32'(1'b0));
        for (int i = 0; i < BS; i++) pop(0);
        chk("onoff0_drained", 32'(is_on_off_o[0]), 32'(1'b1));
        pop(0);

        // VC2 HEADTAIL into an empty VC with a simultaneous read
        drive(1'b1, 2, HEADTAIL, 16'h4444, 4'b0100);
        chk("alloc2_headtail", 32'(is_allocatable_o[2]), 32'(1'b0));
        pop(2);
        chk("alloc2_after_pop", 32'(is_allocatable_o[2]), 32'(1'b1));

        // Asynchronous reset mid-packet
        wr(0, HEAD, 16'h5001);
        wr(0, BODY, 16'h5002);
        wr(1, HEAD, 16'h6001);
        wr(1, BODY, 16'h6002);
        chk("pre_rst_alloc", 32'(is_allocatable_o), 32'(4'hC));
        rst = 1'b1;
        #1;
        chk("async_rst_empty",  32'(is_empty_o), 32'(4'hF));
        chk("async_rst_alloc",  32'(is_allocatable_o), 32'(4'hF));
        chk("async_rst_on_off", 32'(is_on_off_o), 32'(4'hF));
`ifdef NOC_INBUF_OVERFLOW_DET_EN
        chk("async_rst_ovf", 32'(overflow_o), 32'(1'b0));
`endif
        for (int i = 0; i < VC_NUM; i++) sb_q[i].delete();
        step();
        rst = 1'b0;
        step();

        // Post-reset sanity on VC3
        wr(3, HEAD, 16'h7001);
        chk("alloc3_head", 32'(is_allocatable_o[3]), 32'(1'b0));
        pop(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
